write_data: RTL

Receive-side buffer for the 2-bit H-matrix symbol stream produced by the read sequencer. A frame is 16 symbols × 8 beats of 2-bit data. The block packs each symbol's 8 beats into a 16-bit word and stores the 16 words in an internal buffer. It then signals frame completion, holds the buffer until the consumer acknowledges it, and serves random-access reads from the buffer at any time.

---
 rtl/write_data.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/write_data.sv
// Receive-side frame buffer: packs 2-bit H-matrix beats into 16-bit symbol
// words, holds a completed frame until acknowledged, and serves registered reads.
module write_data (
    input  logic        clk,
    input  logic        rst,
    input  logic        sof,
    input  logic        din_valid,
    input  logic [1:0]  din,
    input  logic        frame_ack,
    input  logic        rd_en,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        full,
    output logic        frame_done,
    output logic [3:0]  sym_cnt,
    output logic        resync_err,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  beat_cnt_r, beat_cnt_s;
    logic [3:0]  sym_cnt_r, sym_cnt_s;
    logic [13:0] shift_r, shift_s;
    logic        resync_err_r, resync_err_s;
    logic        overflow_r, overflow_s;
    logic        frame_done_r, frame_done_s;
    logic        busy_r, full_r;
    logic [15:0] rd_data_r;
    logic        mem_we_s;
    logic [3:0]  mem_waddr_s;
    logic [15:0] mem_wdata_s;
    logic [15:0] mem_r [0:15];

    // Next-state, counter, flag and buffer-write decode.
    always_comb begin
        state_s      = state_r;
        beat_cnt_s   = beat_cnt_r;
        sym_cnt_s    = sym_cnt_r;
        shift_s      = shift_r;
        resync_err_s = resync_err_r;
        overflow_s   = overflow_r;
        frame_done_s = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = sym_cnt_r;
        mem_wdata_s  = {din, shift_r};
        case (state_r)
            IDLE: begin
                if (sof) begin
                    state_s    = RECV;
                    beat_cnt_s = 3'd0;
                    sym_cnt_s  = 4'd0;
                    shift_s    = 14'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            RECV: begin
                // The 128th beat wins over a coincident sof; that sof counts as arriving in FULL.
                if (din_valid && (beat_cnt_r == 3'd7) && (sym_cnt_r == 4'd15)) begin
                    mem_we_s     = 1'b1;
                    frame_done_s = 1'b1;
                    state_s      = FULL;
                    beat_cnt_s   = 3'd0;
                    sym_cnt_s    = 4'd0;
                    if (sof) begin
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = overflow_r;
                    end
                end else if (sof) begin
                    beat_cnt_s   = 3'd0;
                    sym_cnt_s    = 4'd0;
                    shift_s      = 14'd0;
                    resync_err_s = 1'b1;
                end else if (din_valid) begin
                    if (beat_cnt_r == 3'd7) begin
                        mem_we_s   = 1'b1;
                        beat_cnt_s = 3'd0;
                        sym_cnt_s  = sym_cnt_r + 4'd1;
                    end else begin
                        shift_s    = {din, shift_r[13:2]};
                        beat_cnt_s = beat_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = RECV;
                end
            end
            FULL: begin
                if (frame_ack) begin
                    resync_err_s = 1'b0;
                    overflow_s   = 1'b0;
                    if (sof) begin
                        state_s    = RECV;
                        beat_cnt_s = 3'd0;
                        sym_cnt_s  = 4'd0;
                        shift_s    = 14'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (sof) begin
                    overflow_s = 1'b1;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s    = IDLE;
                beat_cnt_s = 3'd0;
                sym_cnt_s  = 4'd0;
                shift_s    = 14'd0;
            end
        endcase
    end

    // Control state, counters, flags, status outputs and read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            beat_cnt_r   <= 3'd0;
            sym_cnt_r    <= 4'd0;
            shift_r      <= 14'd0;
            resync_err_r <= 1'b0;
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            full_r       <= 1'b0;
            rd_data_r    <= 16'd0;
        end else begin
            state_r      <= state_s;
            beat_cnt_r   <= beat_cnt_s;
            sym_cnt_r    <= sym_cnt_s;
            shift_r      <= shift_s;
            resync_err_r <= resync_err_s;
            overflow_r   <= overflow_s;
            frame_done_r <= frame_done_s;
            busy_r       <= (state_s != IDLE);
            full_r       <= (state_s == FULL);
            if (rd_en) begin
                rd_data_r <= mem_r[rd_addr];
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    // Symbol buffer storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign rd_data    = rd_data_r;
    assign busy       = busy_r;
    assign full       = full_r;
    assign frame_done = frame_done_r;
    assign sym_cnt    = sym_cnt_r;
    assign resync_err = resync_err_r;
    assign overflow   = overflow_r;

endmodule
